// File: rtl/i2s_tx_fifo.sv
// Transmit sample FIFO between the APB audio registers and the I2S engine.
// Show-ahead head sample, fill level, low-water interrupt and sticky status.
module i2s_tx_fifo #(
  parameter int unsigned AW = 3,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [DW-1:0] wr_data,
  input  logic          fifo_clear,
  input  logic [AW:0]   tx_thresh,
  output logic [DW-1:0] data_in,
  output logic          data_in_valid,
  input  logic          data_in_ack,
  input  logic          tx_underrun,
  output logic [AW:0]   level,
  output logic          full,
  output logic          tx_irq,
  output logic          overflow_st,
  output logic          underrun_st,
  input  logic          status_clr
);

  localparam int unsigned Depth = 2 ** AW;
  localparam logic [AW:0] FullLevel = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] PtrInc = (AW + 1)'(1);

  logic [DW-1:0] mem_q [Depth];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          overflow_q, underrun_q, tx_irq_q;
  logic          pop, push, overflow_evt;

  always_comb begin
    level         = wr_ptr_q - rd_ptr_q;
    full          = (level == FullLevel);
    data_in_valid = (level != '0);
    // Mask the head when empty so no stale sample reaches the engine.
    data_in       = data_in_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
    pop           = data_in_ack & data_in_valid;
    push          = wr_en & (~full | pop);
    overflow_evt  = wr_en & full & ~pop & ~fifo_clear;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
      tx_irq_q   <= 1'b1;
    end else begin
      if (fifo_clear) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + PtrInc;
        if (pop)  rd_ptr_q <= rd_ptr_q + PtrInc;
      end
      // Set has priority over a coincident clear.
      if (overflow_evt)    overflow_q <= 1'b1;
      else if (status_clr) overflow_q <= 1'b0;
      if (tx_underrun)     underrun_q <= 1'b1;
      else if (status_clr) underrun_q <= 1'b0;
      tx_irq_q <= (level <= tx_thresh);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !fifo_clear && push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign overflow_st = overflow_q;
  assign underrun_st = underrun_q;
  assign tx_irq      = tx_irq_q;

endmodule
